// File: rtl/seq_divider32.sv
// seq_divider32: sequential radix-2 restoring divider, signed or unsigned.
// One quotient bit per clock; results are sign-corrected and registered one
// edge after the last iteration, with a single-cycle done pulse.
// Optional macro SEQ_DIVIDER32_DZ_FAST_EN adds a dz output and resolves a zero
// divisor in one cycle instead of running the full iteration.
module seq_divider32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sign,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
   ,
   output logic             dz
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CntLoad = CW'(WIDTH - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       st_q, st_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, becomes quotient
   logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
   logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fin_q, fin_d;   // iterations complete, result edge next
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             done_q, done_d;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
   logic             dz_q, dz_d;
`endif

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   trial, diff;
   logic             accept;

   // Operand magnitudes; only negative values in signed mode are negated
   always_comb begin
      a_mag = (sign && A[WIDTH-1]) ? (~A + 1'b1) : A;
      b_mag = (sign && B[WIDTH-1]) ? (~B + 1'b1) : B;
   end

   assign accept = start && (st_q != StRun);
   assign trial  = {rem_q, dvd_q[WIDTH-1]};
   assign diff   = trial - {1'b0, dvs_q};

   // Next-state: accept, per-bit restoring step, and sign-corrected result
   always_comb begin
      st_d   = st_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      rem_d  = rem_q;
      q_d    = q_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      fin_d  = fin_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      done_d = 1'b0;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
      dz_d   = dz_q;
`endif
      if (st_q == StRun) begin
         if (fin_q) begin
            q_d    = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
            r_d    = rneg_q ? (~rem_q + 1'b1) : rem_q;
            done_d = 1'b1;
            st_d   = StDone;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
            // A zero divisor only reaches this point via the fast path
            dz_d   = (dvs_q == '0);
`endif
         end else begin
            if (!diff[WIDTH]) begin
               rem_d = diff[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = trial[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
               fin_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      end else if (accept) begin
         dvd_d  = a_mag;
         dvs_d  = b_mag;
         rem_d  = '0;
         cnt_d  = CntLoad;
         fin_d  = 1'b0;
         qneg_d = sign & (A[WIDTH-1] ^ B[WIDTH-1]);
         rneg_d = sign & A[WIDTH-1];
         st_d   = StRun;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
         dz_d   = 1'b0;
         if (B == '0) begin
            // Preload the final answer and go straight to the result edge
            dvd_d  = '1;
            rem_d  = A;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
            fin_d  = 1'b1;
         end
`endif
      end else if (st_q == StDone) begin
         st_d = StIdle;
      end
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= StIdle;
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         q_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         fin_q  <= 1'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         done_q <= 1'b0;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
         dz_q   <= 1'b0;
`endif
      end else begin
         st_q   <= st_d;
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         q_q    <= q_d;
         r_q    <= r_d;
         cnt_q  <= cnt_d;
         fin_q  <= fin_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         done_q <= done_d;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
         dz_q   <= dz_d;
`endif
      end
   end

   assign busy = (st_q == StRun);
   assign done = done_q;
   assign Q    = q_q;
   assign R    = r_q;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
   assign dz   = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider32.sv
// Scoreboard bench for seq_divider32: stimulus pushes expected results from
// an arithmetic reference model; an independent monitor pops on each done.
module tb_seq_divider32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sign = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done;
   logic [31:0] Q, R;
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
   logic        dz;
`endif

   seq_divider32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .sign  (sign),
      .busy  (busy),
      .done  (done),
      .Q     (Q),
      .R     (R)
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
      ,
      .dz    (dz)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
      int          at;
   } exp_t;

   exp_t sbq[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division on 64-bit values, special cases for /0
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic z, output int lat);
      longint sa, sb;
      lat = 33;
      z   = 1'b0;
      if (b == 32'd0) begin
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
         q   = 32'hFFFF_FFFF;
         r   = a;
         z   = 1'b1;
         lat = 1;
`else
         q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
         r = a;
`endif
      end else begin
         if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
         end
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
   endfunction

   // Drive start now; it is accepted on the next rising edge
   task automatic issue_now(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      int   lat;
      A     = a;
      B     = b;
      sign  = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      model(a, b, s, e.q, e.r, e.z, lat);
      e.at = cyc + lat;
      sbq.push_back(e);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         n_chk++;
         n_fail++;
         $display("FAIL issue_wait: busy=1 after %0d cycles, required 0", n);
      end else begin
         issue_now(a, b, s);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_done: done=0 after %0d cycles, required 1", n);
      end
   endtask

   // Monitor: compare every done against the oldest expected result
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_done = 1'b0;
         end else begin
            if (done) begin
               chk("done_single_cycle", 32'(prev_done), 32'd0);
               chk("busy_low_at_done", 32'(busy), 32'd0);
               if (sbq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
               end else begin
                  e = sbq.pop_front();
                  chk("quotient", Q, e.q);
                  chk("remainder", R, e.r);
                  chk("latency", 32'(cyc), 32'(e.at));
`ifdef SEQ_DIVIDER32_DZ_FAST_EN
                  chk("dz", 32'(dz), 32'(e.z));
`endif
               end
            end
            prev_done = done;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          n;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_q", Q, 32'd0);
      chk("reset_r", R, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned basic, with busy observed during the run
      issue(32'd100, 32'd7, 1'b0);
      @(negedge clk);
      chk("busy_early", 32'(busy), 32'd1);
      repeat (30) @(negedge clk);
      chk("busy_late", 32'(busy), 32'd1);

      // Signed, overflow, extremes, divide by zero
      issue(32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(32'd7, 32'hFFFF_FFFE, 1'b1);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(32'hFFFF_FFFF, 32'd1, 1'b0);
      issue(32'd5, 32'd0, 1'b0);
      issue(32'hFFFF_FFFB, 32'd0, 1'b1);
      issue(32'd5, 32'd0, 1'b1);
      issue(32'd0, 32'd3, 1'b1);

      // Start while busy is ignored; start in the done cycle is accepted
      issue(32'd1000, 32'd9, 1'b0);
      repeat (5) @(negedge clk);
      A = 32'd9;
      B = 32'd3;
      sign = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue_now(32'd9, 32'd3, 1'b0);

      // Randomized operations, some back-to-back, some with gaps
      for (int i = 0; i < 40; i++) begin
         rs = 1'(($urandom_range(0, 1)));
         ra = $urandom;
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         issue(ra, rb, rs);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
      end

      // Reset mid-operation: outputs clear at once, no done afterwards
      issue(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_q", Q, 32'd0);
      chk("abort_r", R, 32'd0);
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'd0);

      // Recovery after reset
      issue(32'd81, 32'd9, 1'b0);

      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
